// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending (scoreboard) bit and a pending count.
// Define RF_BYPASS_EN for write-first reads; the default build reads stored state only.
module regfile_scoreboard #(
    parameter int AWL   = 5,
    parameter int DWL   = 32,
    parameter int DEPTH = 2 ** AWL
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           RFWE,
    input  logic [AWL-1:0] RFWA,
    input  logic [DWL-1:0] RFWD,
    input  logic [AWL-1:0] RFRA1,
    input  logic [AWL-1:0] RFRA2,
    output logic [DWL-1:0] RFRD1,
    output logic [DWL-1:0] RFRD2,
    input  logic           RSVE,
    input  logic [AWL-1:0] RSVA,
    output logic           BUSY1,
    output logic           BUSY2,
    output logic [AWL:0]   PCNT
);

    logic [DWL-1:0]   regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [AWL:0]     pcnt;
    logic             wr_ok;
    logic             rsv_ok;
    logic             set_eff;
    logic             clr_eff;

    assign wr_ok  = RFWE && (RFWA != '0);
    assign rsv_ok = RSVE && (RSVA != '0);

    // A same-address reserve wins over the write's clear, so that write cannot drop the count.
    assign set_eff = rsv_ok && !pending[RSVA];
    assign clr_eff = wr_ok && pending[RFWA] && !(rsv_ok && (RSVA == RFWA));

    assign PCNT = pcnt;

    // NOTE: the register array is reset on purpose; reads must return 0 for every register after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
            pcnt    <= '0;
        end else begin
            // NOTE: non-blocking order matters here: the later reserve set overrides the write clear.
            if (wr_ok) begin
                regs[RFWA]    <= RFWD;
                pending[RFWA] <= 1'b0;
            end
            if (rsv_ok) begin
                pending[RSVA] <= 1'b1;
            end
            pcnt <= pcnt + {{AWL{1'b0}}, set_eff} - {{AWL{1'b0}}, clr_eff};
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        RFRD1 = regs[RFRA1];
        BUSY1 = pending[RFRA1];
`ifdef RF_BYPASS_EN
        if (wr_ok && (RFWA == RFRA1)) begin
            RFRD1 = RFWD;
            BUSY1 = 1'b0;
        end
`endif
        if (RST || (RFRA1 == '0)) begin
            RFRD1 = '0;
            BUSY1 = 1'b0;
        end
    end

    always_comb begin
        RFRD2 = regs[RFRA2];
        BUSY2 = pending[RFRA2];
`ifdef RF_BYPASS_EN
        if (wr_ok && (RFWA == RFRA2)) begin
            RFRD2 = RFWD;
            BUSY2 = 1'b0;
        end
`endif
        if (RST || (RFRA2 == '0)) begin
            RFRD2 = '0;
            BUSY2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: an array/bitmask model checked every negedge,
// plus literal expectations for the reset, zero-register, scoreboard, collision, bypass and sweep cases.
module tb_regfile_scoreboard;

    localparam int AWL = 5;
    localparam int DWL = 32;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           RFWE = 1'b0;
    logic [AWL-1:0] RFWA = '0;
    logic [DWL-1:0] RFWD = '0;
    logic [AWL-1:0] RFRA1 = '0;
    logic [AWL-1:0] RFRA2 = '0;
    logic [DWL-1:0] RFRD1;
    logic [DWL-1:0] RFRD2;
    logic           RSVE = 1'b0;
    logic [AWL-1:0] RSVA = '0;
    logic           BUSY1;
    logic           BUSY2;
    logic [AWL:0]   PCNT;

    regfile_scoreboard #(.AWL(AWL), .DWL(DWL)) dut (
        .CLK(CLK), .RST(RST),
        .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
        .RFRA1(RFRA1), .RFRA2(RFRA2),
        .RFRD1(RFRD1), .RFRD2(RFRD2),
        .RSVE(RSVE), .RSVA(RSVA),
        .BUSY1(BUSY1), .BUSY2(BUSY2),
        .PCNT(PCNT)
    );

    always #5 CLK = ~CLK;

    // Model: plain array of register values and a bitmask of pending registers.
    bit [DWL-1:0] m_regs [32];
    bit [31:0]    m_pend;
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [AWL-1:0] a);
        if (RST || a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (RFWE && RFWA == a) return RFWD;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AWL-1:0] a);
        if (RST || a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (RFWE && RFWA == a) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pend = '0;
            foreach (m_regs[i]) m_regs[i] = '0;
        end else begin
            if (RFWE && RFWA != 0) begin
                m_regs[RFWA] = RFWD;
                m_pend[RFWA] = 1'b0;
            end
            if (RSVE && RSVA != 0) m_pend[RSVA] = 1'b1;
        end
    end

    always @(negedge CLK) begin
        check("rd1",   RFRD1, exp_rd(RFRA1));
        check("rd2",   RFRD2, exp_rd(RFRA2));
        check("busy1", {31'b0, BUSY1}, {31'b0, exp_busy(RFRA1)});
        check("busy2", {31'b0, BUSY2}, {31'b0, exp_busy(RFRA2)});
        check("pcnt",  {26'b0, PCNT}, RST ? 32'd0 : $countones(m_pend));
    end

    // Returns 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RFWE = 1'b0;
        RSVE = 1'b0;
    endtask

    task automatic wr(input logic [AWL-1:0] a, input logic [DWL-1:0] d);
        RFWE = 1'b1;
        RFWA = a;
        RFWD = d;
    endtask

    task automatic rsv(input logic [AWL-1:0] a);
        RSVE = 1'b1;
        RSVA = a;
    endtask

    typedef struct {
        logic           we;
        logic [AWL-1:0] wa;
        logic [DWL-1:0] wd;
        logic           re;
        logic [AWL-1:0] ra;
        logic [AWL-1:0] a1;
        logic [AWL-1:0] a2;
    } vec_t;

    vec_t mix [6];

    initial begin
        // Power-up reset.
        #1 RST = 1'b1;
        tick();
        #2;
        check("reset_pcnt", {26'b0, PCNT}, 32'd0);
        check("reset_rd1",  RFRD1, 32'd0);
        tick();
        RST = 1'b0;

        // Write r5, reserve r6, then reset mid-cycle with a write pending on the inputs.
        RFRA1 = 5'd5;
        wr(5'd5, 32'hDEADBEEF);
        rsv(5'd6);
        tick();
        idle();
        #2;
        check("r5_before_reset", RFRD1, 32'hDEADBEEF);
        check("pcnt_before_reset", {26'b0, PCNT}, 32'd1);
        RST = 1'b1;
        wr(5'd5, 32'h00000BAD);
        #1;
        check("r5_in_reset",   RFRD1, 32'd0);
        check("pcnt_in_reset", {26'b0, PCNT}, 32'd0);
        tick();
        RST = 1'b0;
        idle();
        tick();
        #2;
        check("r5_after_reset", RFRD1, 32'd0);

        // Zero register: write and reserve r0.
        RFRA1 = 5'd0;
        wr(5'd0, 32'h1234);
        rsv(5'd0);
        tick();
        idle();
        #2;
        check("r0_rd",   RFRD1, 32'd0);
        check("r0_busy", {31'b0, BUSY1}, 32'd0);
        check("r0_pcnt", {26'b0, PCNT}, 32'd0);

        // Scoreboard counting: r3, r7, r3 again, then write r3.
        RFRA1 = 5'd3;
        rsv(5'd3);
        tick();
        #2 check("pcnt_r3", {26'b0, PCNT}, 32'd1);
        check("busy_r3", {31'b0, BUSY1}, 32'd1);
        rsv(5'd7);
        tick();
        #2 check("pcnt_r7", {26'b0, PCNT}, 32'd2);
        rsv(5'd3);
        tick();
        #2 check("pcnt_r3_again", {26'b0, PCNT}, 32'd2);
        idle();
        wr(5'd3, 32'hA5);
        tick();
        idle();
        #2;
        check("pcnt_wr_r3", {26'b0, PCNT}, 32'd1);
        check("busy_wr_r3", {31'b0, BUSY1}, 32'd0);
        check("rd_wr_r3",   RFRD1, 32'hA5);

        // Collision: r9 pending, then write and reserve r9 in one cycle.
        RFRA2 = 5'd9;
        rsv(5'd9);
        tick();
        #2 check("pcnt_r9", {26'b0, PCNT}, 32'd2);
        wr(5'd9, 32'h55);
        rsv(5'd9);
        tick();
        idle();
        #2;
        check("coll_busy", {31'b0, BUSY2}, 32'd1);
        check("coll_rd",   RFRD2, 32'h55);
        check("coll_pcnt", {26'b0, PCNT}, 32'd2);

        // Bypass: old value 0x1111 in r4, then same-cycle write of 0xCAFE.
        RFRA2 = 5'd4;
        wr(5'd4, 32'h1111);
        tick();
        wr(5'd4, 32'hCAFE);
        #2;
`ifdef RF_BYPASS_EN
        check("bypass_same_cycle", RFRD2, 32'hCAFE);
`else
        check("bypass_same_cycle", RFRD2, 32'h1111);
`endif
        tick();
        idle();
        #2 check("bypass_after_edge", RFRD2, 32'hCAFE);

        // Mixed directed vectors: write/reserve on different addresses in one cycle.
        mix[0] = '{1'b1, 5'd11, 32'h0B0B, 1'b1, 5'd10, 5'd10, 5'd11};
        mix[1] = '{1'b1, 5'd10, 32'h0A0A, 1'b1, 5'd11, 5'd10, 5'd11};
        mix[2] = '{1'b1, 5'd11, 32'h1B1B, 1'b1, 5'd11, 5'd11, 5'd7};
        mix[3] = '{1'b1, 5'd7,  32'h0707, 1'b0, 5'd0,  5'd7,  5'd11};
        mix[4] = '{1'b1, 5'd11, 32'h2B2B, 1'b0, 5'd0,  5'd11, 5'd9};
        mix[5] = '{1'b0, 5'd0,  32'hFFFF, 1'b1, 5'd12, 5'd12, 5'd0};
        foreach (mix[i]) begin
            RFWE = mix[i].we; RFWA = mix[i].wa; RFWD = mix[i].wd;
            RSVE = mix[i].re; RSVA = mix[i].ra;
            RFRA1 = mix[i].a1; RFRA2 = mix[i].a2;
            tick();
        end
        idle();
        #2;
        check("mix_pcnt", {26'b0, PCNT}, 32'd2);
        RFRA1 = 5'd11;
        #1 check("mix_r11", RFRD1, 32'h2B2B);

        // Sweep: reserve r1..r31, then write them all.
        for (int i = 1; i < 32; i++) begin
            rsv(i[AWL-1:0]);
            RFRA1 = i[AWL-1:0];
            tick();
        end
        idle();
        #2 check("sweep_full", {26'b0, PCNT}, 32'd31);
        for (int i = 1; i < 32; i++) begin
            wr(i[AWL-1:0], 32'h1000_0000 + i);
            RFRA1 = i[AWL-1:0];
            RFRA2 = 5'(i - 1);
            tick();
        end
        idle();
        #2 check("sweep_empty", {26'b0, PCNT}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            RFRA1 = i[AWL-1:0];
            #1;
            check("sweep_busy", {31'b0, BUSY1}, 32'd0);
            check("sweep_rd",   RFRD1, 32'h1000_0000 + i);
        end
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
